// File: rtl/reg_writeback_queue.sv
// Write-back queue feeding the 32x32 register bank: buffers results, drains one per cycle
// through a registered write port, and forwards queued-but-uncommitted values to decode.
module reg_writeback_queue #(
    parameter int DEPTH   = 4,
    parameter int PTR_W   = 2,
    parameter bit DROP_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              result_valid,
    input  logic [4:0]        result_addr,
    input  logic [31:0]       result_data,
    output logic              result_ready,
    input  logic              wb_hold,
    output logic              regWriteEnable,
    output logic [4:0]        regAddr_write,
    output logic [31:0]       regWriteData,
    input  logic [4:0]        lookup_addr_1,
    input  logic [4:0]        lookup_addr_2,
    output logic              fwd_hit_1,
    output logic [31:0]       fwd_data_1,
    output logic              fwd_hit_2,
    output logic [31:0]       fwd_data_2,
    output logic              queue_empty,
    output logic [PTR_W:0]    count
);

    logic [4:0]       mem_addr_q [DEPTH];
    logic [31:0]      mem_data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             we_q, we_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             push, pop, drop;

    always_comb begin
        result_ready = (count_q < (PTR_W+1)'(DEPTH));
        drop         = DROP_R0 && (result_addr == 5'd0);
        push         = result_valid && result_ready && !drop;
        pop          = (count_q != '0) && !wb_hold;

        // NOTE: every variable gets a default before any branch so no latch is inferred.
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        we_d    = pop;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        if (pop) begin
            waddr_d         = mem_addr_q[head_q];
            wdata_d         = mem_data_q[head_q];
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // NOTE: entry storage is not reset; the valid bits alone decide whether an entry is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[tail_q] <= result_addr;
            mem_data_q[tail_q] <= result_data;
        end
    end

    // Scan oldest to youngest so the youngest matching candidate wins.
    always_comb begin : fwd_comb
        logic [PTR_W-1:0] idx;
        idx        = '0;
        fwd_hit_1  = 1'b0;
        fwd_data_1 = '0;
        fwd_hit_2  = 1'b0;
        fwd_data_2 = '0;
        if (we_q && waddr_q == lookup_addr_1) begin
            fwd_hit_1  = 1'b1;
            fwd_data_1 = wdata_q;
        end
        if (we_q && waddr_q == lookup_addr_2) begin
            fwd_hit_2  = 1'b1;
            fwd_data_2 = wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && mem_addr_q[idx] == lookup_addr_1) begin
                fwd_hit_1  = 1'b1;
                fwd_data_1 = mem_data_q[idx];
            end
            if (valid_q[idx] && mem_addr_q[idx] == lookup_addr_2) begin
                fwd_hit_2  = 1'b1;
                fwd_data_2 = mem_data_q[idx];
            end
        end
        if (DROP_R0 && lookup_addr_1 == 5'd0) begin
            fwd_hit_1  = 1'b0;
            fwd_data_1 = '0;
        end
        if (DROP_R0 && lookup_addr_2 == 5'd0) begin
            fwd_hit_2  = 1'b0;
            fwd_data_2 = '0;
        end
    end

    assign regWriteEnable = we_q;
    assign regAddr_write  = waddr_q;
    assign regWriteData   = wdata_q;
    assign queue_empty    = (count_q == '0) && !we_q;
    assign count          = count_q;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Randomized self-checking bench for reg_writeback_queue against a queue-based reference model,
// plus a second instance built with DROP_R0=1.
module tb_reg_writeback_queue;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        result_valid = 1'b0, d_valid = 1'b0, wb_hold = 1'b0;
    logic [4:0]  result_addr = '0, l1 = '0, l2 = '0;
    logic [31:0] result_data = '0;

    logic        ready, we, hit1, hit2, empty;
    logic [4:0]  waddr;
    logic [31:0] wdata, data1, data2;
    logic [2:0]  cnt;

    logic        d_ready, d_we, d_hit1, d_hit2, d_empty;
    logic [4:0]  d_waddr;
    logic [31:0] d_wdata, d_data1, d_data2;
    logic [2:0]  d_cnt;

    always #5 clk = ~clk;

    reg_writeback_queue #(.DEPTH(4), .PTR_W(2), .DROP_R0(1'b0)) dut (
        .clk(clk), .rst(rst),
        .result_valid(result_valid), .result_addr(result_addr), .result_data(result_data),
        .result_ready(ready), .wb_hold(wb_hold),
        .regWriteEnable(we), .regAddr_write(waddr), .regWriteData(wdata),
        .lookup_addr_1(l1), .lookup_addr_2(l2),
        .fwd_hit_1(hit1), .fwd_data_1(data1), .fwd_hit_2(hit2), .fwd_data_2(data2),
        .queue_empty(empty), .count(cnt)
    );

    reg_writeback_queue #(.DEPTH(4), .PTR_W(2), .DROP_R0(1'b1)) dut_drop (
        .clk(clk), .rst(rst),
        .result_valid(d_valid), .result_addr(result_addr), .result_data(result_data),
        .result_ready(d_ready), .wb_hold(wb_hold),
        .regWriteEnable(d_we), .regAddr_write(d_waddr), .regWriteData(d_wdata),
        .lookup_addr_1(l1), .lookup_addr_2(l2),
        .fwd_hit_1(d_hit1), .fwd_data_1(d_data1), .fwd_hit_2(d_hit2), .fwd_data_2(d_data2),
        .queue_empty(d_empty), .count(d_cnt)
    );

    // Bank as seen by the write port of the main instance.
    logic [31:0] bank_act [32];
    always @(posedge clk) if (we) bank_act[waddr] <= wdata;

    // Reference model: pending entries, output register, committed bank.
    ent_t        mq[$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_bank [32];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] model_fwd(input logic [4:0] la);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a == la) return {1'b1, mq[i].d};
        if (m_we && m_addr == la) return {1'b1, m_data};
        return '0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // Drive one cycle of stimulus, check every output against the model, then advance the model.
    task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic h, input logic [4:0] a1, input logic [4:0] a2);
        logic [32:0] f1, f2;
        bit          do_pop, do_push;
        ent_t        e;
        @(negedge clk);
        result_valid = v;
        result_addr  = a;
        result_data  = d;
        wb_hold      = h;
        l1           = a1;
        l2           = a2;
        #1;
        f1 = model_fwd(a1);
        f2 = model_fwd(a2);
        check("ready", ready, (mq.size() < 4) ? 1 : 0);
        check("count", cnt, mq.size());
        check("empty", empty, (mq.size() == 0 && !m_we) ? 1 : 0);
        check("we", we, m_we);
        check("waddr", waddr, m_addr);
        check("wdata", wdata, m_data);
        check("hit1", hit1, f1[32]);
        check("fdata1", data1, f1[31:0]);
        check("hit2", hit2, f2[32]);
        check("fdata2", data2, f2[31:0]);
        do_pop  = (mq.size() > 0) && !h;
        do_push = v && (mq.size() < 4);
        @(posedge clk);
        if (m_we) m_bank[m_addr] = m_data;
        if (do_pop) begin
            e      = mq.pop_front();
            m_we   = 1'b1;
            m_addr = e.a;
            m_data = e.d;
        end else begin
            m_we = 1'b0;
        end
        if (do_push) mq.push_back({a, d});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            bank_act[i] = '0;
            m_bank[i]   = '0;
        end
        model_reset();

        // Reset state
        @(negedge clk);
        #1;
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_empty", empty, 1);
        check("rst_count", cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single push reaches the bank two edges later
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
        idle(4);
        check("t1_bank_r5", bank_act[5], 32'hDEADBEEF);

        // Fill under hold, refused fifth offer, ordered drain
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'(i * 'h11), 1'b1, 5'd1, 5'd4);
        step(1'b1, 5'd5, 32'h55, 1'b1, 5'd2, 5'd5);
        idle(6);
        for (int i = 1; i <= 4; i++) check("t2_bank", bank_act[i], 32'(i * 'h11));
        check("t2_bank_r5", bank_act[5], 32'hDEADBEEF);

        // Forwarding: youngest duplicate wins; miss returns 0
        step(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 5'd3);
        step(1'b1, 5'd7, 32'h2, 1'b1, 5'd7, 5'd3);
        step(1'b1, 5'd3, 32'h9, 1'b1, 5'd7, 5'd3);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd3);
        check("t3_fdata1", data1, 32'h2);
        check("t3_fdata2", data2, 32'h9);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd8);
        check("t3_miss_hit", hit1, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd3);

        // Full queue streaming: push and pop every edge, pointers wrap
        for (int i = 0; i < 4; i++) step(1'b1, 5'($urandom_range(0, 7)), $urandom, 1'b1, 5'd0, 5'd1);
        for (int i = 0; i < 14; i++)
            step(1'b1, 5'($urandom_range(0, 7)), $urandom, 1'b0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        idle(6);

        // Asynchronous reset with 3 queued and a strobe active
        for (int i = 0; i < 4; i++) step(1'b1, 5'(10 + i), $urandom, 1'b1, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        @(negedge clk);
        #1;
        check("t5_pre_we", we, 1);
        check("t5_pre_count", cnt, 3);
        #2;
        rst = 1'b1;
        #1;
        check("t5_we", we, 0);
        check("t5_count", cnt, 0);
        check("t5_empty", empty, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        for (int i = 10; i < 14; i++) check("t5_no_commit", bank_act[i], 0);

        // DROP_R0 instance: address 0 accepted and discarded, others pass
        @(negedge clk);
        d_valid = 1'b1; result_addr = 5'd0; result_data = 32'h55; l1 = 5'd0; l2 = 5'd6;
        #1;
        check("t6_ready", d_ready, 1);
        @(negedge clk);
        d_valid = 1'b0;
        #1;
        check("t6_count", d_cnt, 0);
        check("t6_hit_r0", d_hit1, 0);
        @(negedge clk);
        #1;
        check("t6_we", d_we, 0);
        check("t6_empty", d_empty, 1);
        d_valid = 1'b1; result_addr = 5'd6; result_data = 32'h66;
        @(negedge clk);
        d_valid = 1'b0;
        #1;
        check("t6_count6", d_cnt, 1);
        check("t6_hit6", d_hit2, 1);
        check("t6_data6", d_data2, 32'h66);
        @(negedge clk);
        #1;
        check("t6_we6", d_we, 1);
        check("t6_waddr6", d_waddr, 6);

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        idle(6);
        for (int i = 0; i < 32; i++) check("bank_final", bank_act[i], m_bank[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
